// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync bundle type for the VGA timing generator.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

    // Half-open window test lo <= v < hi on coordinate values.
    function automatic logic in_win(input logic [COORD_W-1:0] v,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register for the {hs_n, vs_n, blank_n} bundle; DEPTH=0 is a wire.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  sync_t d,
    output sync_t q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, en};
            assign q = d;
        end else begin : g_pipe
            sync_t [DEPTH-1:0] stage;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage <= {DEPTH{SYNC_IDLE}};
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel/line/frame timing generator with delayed sync outputs.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter port.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active_pixels,
    output logic               hsync_n,
    output logic               vsync_n,
    output logic               blank_n,
    output logic               frame_start,
    output logic               line_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] X_VIS  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] Y_VIS  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_ON  = COORD_W'(H_VISIBLE + H_FP);
    localparam logic [COORD_W-1:0] HS_OFF = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_ON  = COORD_W'(V_VISIBLE + V_FP);
    localparam logic [COORD_W-1:0] VS_OFF = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic               adv;
    logic               x_wrap;
    logic               y_wrap;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    sync_t              raw;
    sync_t              dly;

    // Counters step on the same edge that raises pix_tick, so x/y are stable
    // for the whole cycle in which downstream logic samples them.
    assign adv    = (div_cnt == DIV_LAST);
    assign x_wrap = (x == X_LAST);
    assign y_wrap = (y == Y_LAST);

    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (adv) begin
            if (x_wrap) begin
                x_nxt = '0;
                y_nxt = y_wrap ? '0 : y + 1'b1;
            end else begin
                x_nxt = x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt       <= '0;
            pix_tick      <= 1'b0;
            x             <= X_LAST;
            y             <= Y_LAST;
            active_pixels <= 1'b0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            div_cnt       <= adv ? '0 : div_cnt + 1'b1;
            pix_tick      <= adv;
            x             <= x_nxt;
            y             <= y_nxt;
            active_pixels <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            line_start    <= adv && x_wrap;
            frame_start   <= adv && x_wrap && y_wrap;
        end
    end

    // active_pixels already tracks the current counters, so it serves as raw blank.
    always_comb begin
        raw.hs_n    = !in_win(x, HS_ON, HS_OFF);
        raw.vs_n    = !in_win(y, VS_ON, VS_OFF);
        raw.blank_n = active_pixels;
    end

    vga_sync_delay #(
        .DEPTH(SYNC_DELAY)
    ) u_sync_delay (
        .clk(clk),
        .rst(rst),
        .en (adv),
        .d  (raw),
        .q  (dly)
    );

    assign hsync_n = dly.hs_n;
    assign vsync_n = dly.vs_n;
    assign blank_n = dly.blank_n;

`ifdef VGA_FRAME_CNT_EN
    // The wrap out of reset is not a completed frame, so it only arms the counter.
    logic first_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt  <= '0;
            first_seen <= 1'b0;
        end else if (adv && x_wrap && y_wrap) begin
            if (first_seen) frame_cnt <= frame_cnt + 1'b1;
            first_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the pixel coordinate stream (x, y, active_pixels) that the screen renderers consume.
- Produces the matching VGA sync and blank signals for the DAC.
- Timing is 640x480@60 from the system clock, using a pixel-tick enable.
- Sits between the top-level clock and every renderer and output mux; it is the producer side of the x/y/active_pixels interface.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- SYNC_DELAY, 1, pixel ticks that hs_n/vs_n/blank_n lag x/y (0..4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_tick  out  1  high one clk per pixel period; downstream registers colour on it
- x  out  10  horizontal count, 0..H_TOTAL-1
- y  out  10  vertical count, 0..V_TOTAL-1
- active_pixels  out  1  high when x<H_VISIBLE and y<V_VISIBLE
- hsync_n  out  1  horizontal sync, active-low, delayed SYNC_DELAY ticks
- vsync_n  out  1  vertical sync, active-low, delayed SYNC_DELAY ticks
- blank_n  out  1  active_pixels delayed SYNC_DELAY ticks
- frame_start  out  1  one-clk pulse when counters enter (0,0)
- line_start  out  1  one-clk pulse when x enters 0

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). All widths are 10 bits.

Tick generation:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- pix_tick is registered; it is high in the clk cycle after div_cnt==CLK_DIV-1.
- CLK_DIV=1 gives pix_tick permanently high after the first post-reset clk.

Counters (advance only on the cycle pix_tick is high):
- x increments; at H_TOTAL-1 it wraps to 0 and y increments.
- At y=V_TOTAL-1 together with x wrap, y wraps to 0.

Registered status outputs (all update in the same clk as the counters):
- active_pixels, line_start and frame_start are registered.
- line_start and frame_start are high only in that clk.

Sync generation:
- Raw hs is low for H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC (656..751).
- Raw vs is low for 490 <= y < 492.
- Raw hs, raw vs and active are pushed through a SYNC_DELAY-deep shift register, advanced on pix_tick.
- SYNC_DELAY=0 means they are combinationally equal to the raw values from the current counters.

Reset (synchronous, active-high; all values hold for as long as rst is high):
- div_cnt=0, x=H_TOTAL-1, y=V_TOTAL-1.
- active_pixels=0, pix_tick=0, frame_start=0, line_start=0.
- hsync_n=1, vsync_n=1, blank_n=0.
- Delay-line stages reset to hs=1, vs=1, blank=0.
- Consequence: the first pix_tick after release wraps to (0,0) and raises frame_start and line_start.

Boundary conditions:
- Reset mid-frame: all state returns to the reset values in the next clk; no partial line completes.
- Simultaneous x wrap and y wrap: frame_start and line_start are both high in the same clk.
- x and y never exceed H_TOTAL-1 / V_TOTAL-1.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: adds output port frame_cnt (16 bits).
  - Resets to 0.
  - Increments in the clk frame_start is high, except the first frame_start after reset.
  - Wraps 65535 -> 0. Intended for animation and blink timing in renderers.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480@60 default constants, plus H_TOTAL and V_TOTAL;
  - the coordinate width constant (10);
  - a struct for the {hs_n, vs_n, blank_n} sync bundle.
- One sub-module, vga_sync_delay: parameterised-depth shift register of the sync bundle with tick enable and reset values.

Test Plan:
1. Reset and release, CLK_DIV=2 -> during reset x=799, y=524, hsync_n=1, vsync_n=1, blank_n=0. First pix_tick is at clk 2 after release; x=0, y=0, frame_start=1 for exactly 1 clk.
2. Run one full line -> line_start every 1600 clks. With SYNC_DELAY=1, hsync_n is low for exactly 96 ticks, starting on the tick after x=656. active_pixels is high for x=0..639 only.
3. Run one full frame -> frame_start spaced 800*525*2=840000 clks. vsync_n is low for exactly 2 lines starting at y=490, delayed by 1 tick. blank_n=0 for all of y>=480.
4. CLK_DIV=1, SYNC_DELAY=0 -> pix_tick constantly 1 after release. hsync_n falls in the same clk x becomes 656.
5. Assert rst for 1 clk at x=300, y=200 -> next clk x=799, y=524, sync outputs inactive. Normal restart with frame_start as in scenario 1.
6. With VGA_FRAME_CNT_EN defined, run 3 frames -> frame_cnt reads 0, 1, 2 after the first, second and third frame_start. Without the macro, elaboration shows no frame_cnt port.
